// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one data-memory port between CPU and debug
// requesters, with a req/done front end, an en/ready memory side and a watchdog abort.
module mem_arbiter #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 32,
   parameter int TIMEOUT       = 15
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cpu_req,
   input  logic                     cpu_we,
   input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
   input  logic [DATA_WIDTH-1:0]    cpu_wdata,
   output logic [DATA_WIDTH-1:0]    cpu_rdata,
   output logic                     cpu_done,
   output logic                     cpu_stall,
   input  logic                     dbg_req,
   input  logic                     dbg_we,
   input  logic [ADDRESS_WIDTH-1:0] dbg_addr,
   input  logic [DATA_WIDTH-1:0]    dbg_wdata,
   output logic [DATA_WIDTH-1:0]    dbg_rdata,
   output logic                     dbg_done,
   output logic                     mem_en,
   output logic                     mem_we,
   output logic [ADDRESS_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0]    mem_wdata,
   input  logic [DATA_WIDTH-1:0]    mem_rdata,
   input  logic                     mem_ready,
   output logic                     err
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t                   state, state_nx;
   logic [CW-1:0]            cnt, cnt_nx;
   logic                     owner_dbg, owner_dbg_nx;
   logic                     last_dbg, last_dbg_nx;
   logic                     grant_any, grant_dbg, abort;
   logic [DATA_WIDTH-1:0]    cpu_rdata_nx, dbg_rdata_nx, mem_wdata_nx;
   logic [ADDRESS_WIDTH-1:0] mem_addr_nx;
   logic                     cpu_done_nx, dbg_done_nx, mem_en_nx, mem_we_nx, err_nx;

   assign cpu_stall = cpu_req & ~cpu_done;

   // On a tie the port that did not win last time gets the memory.
   assign grant_any = cpu_req | dbg_req;
   assign grant_dbg = dbg_req & (~cpu_req | ~last_dbg);
   assign abort     = ~mem_ready & (cnt == CNT_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         owner_dbg <= 1'b0;
         last_dbg  <= 1'b1;
         cpu_rdata <= '0;
         dbg_rdata <= '0;
         cpu_done  <= 1'b0;
         dbg_done  <= 1'b0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         err       <= 1'b0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         owner_dbg <= owner_dbg_nx;
         last_dbg  <= last_dbg_nx;
         cpu_rdata <= cpu_rdata_nx;
         dbg_rdata <= dbg_rdata_nx;
         cpu_done  <= cpu_done_nx;
         dbg_done  <= dbg_done_nx;
         mem_en    <= mem_en_nx;
         mem_we    <= mem_we_nx;
         mem_addr  <= mem_addr_nx;
         mem_wdata <= mem_wdata_nx;
         err       <= err_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (grant_any) state_nx = BUSY;
         BUSY:    if (mem_ready || abort) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      cnt_nx       = cnt;
      owner_dbg_nx = owner_dbg;
      last_dbg_nx  = last_dbg;
      cpu_rdata_nx = cpu_rdata;
      dbg_rdata_nx = dbg_rdata;
      cpu_done_nx  = 1'b0;
      dbg_done_nx  = 1'b0;
      mem_en_nx    = mem_en;
      mem_we_nx    = mem_we;
      mem_addr_nx  = mem_addr;
      mem_wdata_nx = mem_wdata;
      err_nx       = err;
      case (state)
         IDLE: begin
            if (grant_any) begin
               owner_dbg_nx = grant_dbg;
               last_dbg_nx  = grant_dbg;
               mem_en_nx    = 1'b1;
               mem_we_nx    = grant_dbg ? dbg_we    : cpu_we;
               mem_addr_nx  = grant_dbg ? dbg_addr  : cpu_addr;
               mem_wdata_nx = grant_dbg ? dbg_wdata : cpu_wdata;
               cnt_nx       = '0;
            end
         end
         BUSY: begin
            // A ready on the final watchdog cycle completes normally.
            if (mem_ready || abort) begin
               mem_en_nx   = 1'b0;
               cpu_done_nx = ~owner_dbg;
               dbg_done_nx = owner_dbg;
               if (mem_ready) begin
                  if (!mem_we) begin
                     if (owner_dbg) dbg_rdata_nx = mem_rdata;
                     else           cpu_rdata_nx = mem_rdata;
                  end
               end else begin
                  err_nx = 1'b1;
                  if (owner_dbg) dbg_rdata_nx = '0;
                  else           cpu_rdata_nx = '0;
               end
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed scenario tests for mem_arbiter
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_req, cpu_we, cpu_done, cpu_stall;
   logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic        dbg_req, dbg_we, dbg_done;
   logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
   logic        mem_en, mem_we, mem_ready, err;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   int pass_cnt = 0;
   int chk_cnt  = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32), .TIMEOUT(15)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_stall(cpu_stall),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_rdata(dbg_rdata), .dbg_done(dbg_done),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready), .err(err)
   );

   task automatic do_reset;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset;
      cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
      dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
      mem_ready = 0; mem_rdata = 0;
      do_reset();
      #1;
      chk_cnt++;
      if ({mem_en, mem_we, cpu_done, dbg_done, err, cpu_stall} !== 6'b0 ||
          mem_addr !== 0 || mem_wdata !== 0 || cpu_rdata !== 0 || dbg_rdata !== 0)
         $display("FAIL reset_outputs: en=%b we=%b cd=%b dd=%b err=%b addr=%h cr=%h dr=%h, want all 0",
                  mem_en, mem_we, cpu_done, dbg_done, err, mem_addr, cpu_rdata, dbg_rdata);
      else pass_cnt++;
   endtask

   task automatic test_cpu_read;
      @(negedge clk);
      cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
      mem_ready = 1; mem_rdata = 32'hCAFEF00D;
      #1;
      chk_cnt++;
      if (cpu_stall !== 1'b1 || mem_en !== 1'b0)
         $display("FAIL rd_c0: stall=%b en=%b, want stall=1 en=0", cpu_stall, mem_en);
      else pass_cnt++;
      @(negedge clk);
      chk_cnt++;
      if (mem_en !== 1'b1 || mem_addr !== 32'h10 || mem_we !== 1'b0 || cpu_stall !== 1'b1 || cpu_done !== 1'b0)
         $display("FAIL rd_c1: en=%b addr=%h we=%b stall=%b done=%b, want 1/10/0/1/0",
                  mem_en, mem_addr, mem_we, cpu_stall, cpu_done);
      else pass_cnt++;
      @(negedge clk);
      chk_cnt++;
      if (cpu_done !== 1'b1 || cpu_rdata !== 32'hCAFEF00D || cpu_stall !== 1'b0 || mem_en !== 1'b0 || err !== 1'b0)
         $display("FAIL rd_c2: done=%b rdata=%h stall=%b en=%b err=%b, want 1/cafef00d/0/0/0",
                  cpu_done, cpu_rdata, cpu_stall, mem_en, err);
      else pass_cnt++;
      cpu_req = 0; mem_ready = 0;
      @(negedge clk);
      chk_cnt++;
      if (cpu_done !== 1'b0 || dbg_done !== 1'b0 || mem_en !== 1'b0)
         $display("FAIL rd_c3: done=%b dbg_done=%b en=%b, want 0/0/0", cpu_done, dbg_done, mem_en);
      else pass_cnt++;
   endtask

   task automatic test_dbg_write_wait;
      int done_cycles = 0;
      int held_bad = 0;
      @(negedge clk);
      dbg_req = 1; dbg_we = 1; dbg_addr = 32'h40; dbg_wdata = 32'h12345678;
      mem_ready = 0; mem_rdata = 32'hDEADBEEF;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         if (c <= 4 && (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h40 || mem_wdata !== 32'h12345678))
            held_bad++;
         if (dbg_done === 1'b1) done_cycles++;
         if (c == 4) mem_ready = 1;
         if (c == 5) begin
            chk_cnt++;
            if (dbg_done !== 1'b1 || dbg_rdata !== 32'h0 || cpu_done !== 1'b0 || mem_en !== 1'b0)
               $display("FAIL wr_done: dd=%b dr=%h cd=%b en=%b, want 1/0/0/0", dbg_done, dbg_rdata, cpu_done, mem_en);
            else pass_cnt++;
            dbg_req = 0; mem_ready = 0;
         end
      end
      chk_cnt++;
      if (held_bad !== 0)
         $display("FAIL wr_held: %0d busy cycles with wrong mem_*, want 0", held_bad);
      else pass_cnt++;
      chk_cnt++;
      if (done_cycles !== 1)
         $display("FAIL wr_done_width: dbg_done high %0d cycles, want 1", done_cycles);
      else pass_cnt++;
   endtask

   task automatic test_tie;
      logic [31:0] exp_addr [12];
      logic        exp_en [12];
      logic        exp_cd [12];
      logic        exp_dd [12];
      int bad = 0;
      do_reset();
      for (int k = 0; k < 12; k++) begin
         exp_en[k] = (k % 3 == 1);
         exp_addr[k] = ((k / 3) % 2 == 0) ? 32'h100 : 32'h200;
         exp_cd[k] = (k == 2 || k == 8);
         exp_dd[k] = (k == 5 || k == 11);
      end
      @(negedge clk);
      cpu_req = 1; cpu_we = 0; cpu_addr = 32'h100;
      dbg_req = 1; dbg_we = 0; dbg_addr = 32'h200;
      mem_ready = 1; mem_rdata = 32'h0000_1111;
      for (int k = 0; k < 12; k++) begin
         if (k > 0) @(negedge clk);
         #1;
         if (mem_en !== exp_en[k] || cpu_done !== exp_cd[k] || dbg_done !== exp_dd[k] ||
             (exp_en[k] && mem_addr !== exp_addr[k])) begin
            bad++;
            $display("FAIL tie_cycle%0d: en=%b addr=%h cd=%b dd=%b, want %b/%h/%b/%b",
                     k, mem_en, mem_addr, cpu_done, dbg_done, exp_en[k], exp_addr[k], exp_cd[k], exp_dd[k]);
         end
      end
      chk_cnt++;
      if (bad == 0) pass_cnt++;
      cpu_req = 0; dbg_req = 0; mem_ready = 0;
      @(negedge clk);
   endtask

   task automatic test_boundary;
      int en_bad = 0;
      do_reset();
      @(negedge clk);
      cpu_req = 1; cpu_we = 0; cpu_addr = 32'h84; mem_ready = 0; mem_rdata = 32'h0BADCAFE;
      for (int c = 1; c <= 15; c++) begin
         @(negedge clk);
         if (mem_en !== 1'b1 || cpu_done !== 1'b0) en_bad++;
      end
      mem_ready = 1;
      @(negedge clk);
      chk_cnt++;
      if (en_bad !== 0)
         $display("FAIL bnd_busy: %0d bad busy cycles, want 0", en_bad);
      else pass_cnt++;
      chk_cnt++;
      if (cpu_done !== 1'b1 || cpu_rdata !== 32'h0BADCAFE || err !== 1'b0)
         $display("FAIL bnd_done: done=%b rdata=%h err=%b, want 1/0badcafe/0", cpu_done, cpu_rdata, err);
      else pass_cnt++;
      cpu_req = 0; mem_ready = 0;
      @(negedge clk);
   endtask

   task automatic test_timeout;
      int en_cycles = 0;
      @(negedge clk);
      cpu_req = 1; cpu_we = 0; cpu_addr = 32'h80; mem_ready = 0; mem_rdata = 32'h77777777;
      for (int c = 1; c <= 15; c++) begin
         @(negedge clk);
         if (mem_en === 1'b1 && cpu_done === 1'b0) en_cycles++;
      end
      @(negedge clk);
      chk_cnt++;
      if (en_cycles !== 15 || mem_en !== 1'b0)
         $display("FAIL to_en_cycles: %0d cycles then en=%b, want 15 then 0", en_cycles, mem_en);
      else pass_cnt++;
      chk_cnt++;
      if (cpu_done !== 1'b1 || cpu_rdata !== 32'h0 || err !== 1'b1)
         $display("FAIL to_abort: done=%b rdata=%h err=%b, want 1/0/1", cpu_done, cpu_rdata, err);
      else pass_cnt++;
      cpu_req = 0;
      @(negedge clk);
      cpu_req = 1; cpu_addr = 32'h88; mem_ready = 1; mem_rdata = 32'h000055AA;
      repeat (2) @(negedge clk);
      chk_cnt++;
      if (cpu_done !== 1'b1 || cpu_rdata !== 32'h000055AA || err !== 1'b1)
         $display("FAIL to_sticky: done=%b rdata=%h err=%b, want 1/000055aa/1", cpu_done, cpu_rdata, err);
      else pass_cnt++;
      cpu_req = 0; mem_ready = 0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid;
      int late_done = 0;
      @(negedge clk);
      cpu_req = 1; cpu_we = 0; cpu_addr = 32'h90; mem_ready = 0;
      repeat (3) @(negedge clk);
      chk_cnt++;
      if (mem_en !== 1'b1 || err !== 1'b1)
         $display("FAIL rm_busy: en=%b err=%b, want 1/1", mem_en, err);
      else pass_cnt++;
      rst = 1'b1;
      #1;
      chk_cnt++;
      if (mem_en !== 1'b0 || cpu_done !== 1'b0 || dbg_done !== 1'b0 || err !== 1'b0)
         $display("FAIL rm_async: en=%b cd=%b dd=%b err=%b, want 0/0/0/0", mem_en, cpu_done, dbg_done, err);
      else pass_cnt++;
      cpu_req = 0;
      @(negedge clk);
      rst = 1'b0;
      mem_ready = 1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (cpu_done !== 1'b0 || dbg_done !== 1'b0 || mem_en !== 1'b0) late_done++;
      end
      chk_cnt++;
      if (late_done !== 0)
         $display("FAIL rm_no_done: %0d cycles with activity after reset, want 0", late_done);
      else pass_cnt++;
      cpu_req = 1; cpu_addr = 32'h300; dbg_req = 1; dbg_addr = 32'h400;
      @(negedge clk);
      chk_cnt++;
      if (mem_en !== 1'b1 || mem_addr !== 32'h300)
         $display("FAIL rm_tie_cpu: en=%b addr=%h, want 1/00000300", mem_en, mem_addr);
      else pass_cnt++;
      cpu_req = 0; dbg_req = 0; mem_ready = 0;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_cpu_read();
      test_dbg_write_wait();
      test_tie();
      test_boundary();
      test_timeout();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single data-memory port between two requesters: the CPU load/store path and a debug/program-loader port. Each access follows a req/done handshake. The memory side follows an enable/ready handshake with variable latency. Round-robin arbitration resolves simultaneous requests. A watchdog aborts accesses the memory never acknowledges. The block sits between the CPU datapath and the data-memory file, and its stall output freezes the CPU while an access is pending.

Parameters:
DATA_WIDTH, 32, width of read/write data
ADDRESS_WIDTH, 32, width of memory address
TIMEOUT, 15, max BUSY cycles without mem_ready before abort (>=1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
cpu_req  input  1  CPU access request, held until cpu_done
cpu_we  input  1  CPU write enable (1=store, 0=load)
cpu_addr  input  ADDRESS_WIDTH  CPU byte address
cpu_wdata  input  DATA_WIDTH  CPU store data
cpu_rdata  output  DATA_WIDTH  CPU load result, registered
cpu_done  output  1  one-cycle completion pulse to CPU
cpu_stall  output  1  cpu_req & ~cpu_done, combinational
dbg_req  input  1  debug access request, held until dbg_done
dbg_we  input  1  debug write enable
dbg_addr  input  ADDRESS_WIDTH  debug address
dbg_wdata  input  DATA_WIDTH  debug write data
dbg_rdata  output  DATA_WIDTH  debug read result, registered
dbg_done  output  1  one-cycle completion pulse to debug port
mem_en  output  1  memory access strobe, held through BUSY
mem_we  output  1  memory write enable
mem_addr  output  ADDRESS_WIDTH  memory address
mem_wdata  output  DATA_WIDTH  memory write data
mem_rdata  input  DATA_WIDTH  memory read data, valid with mem_ready
mem_ready  input  1  memory acknowledge
err  output  1  sticky timeout flag

Behaviour:
- Reset (asynchronous, immediate, including mid-access):
  - state=IDLE; every output 0; timeout counter 0.
  - last_grant=DBG, so the CPU wins the first tie.
  - Any access in flight is dropped; no done pulse is issued.
- All outputs except cpu_stall are registered.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - No request: stay in IDLE with mem_en=0.
  - Exactly one request: grant it.
  - Both request: grant the port that is not last_grant, then update last_grant.
  - On the grant edge: latch we/addr/wdata into mem_we/mem_addr/mem_wdata, set mem_en=1, clear counter, go to BUSY.
- BUSY:
  - mem_* outputs are held stable; requester inputs are ignored (no mid-access update).
  - mem_ready=1: on that edge, mem_en<=0, owner's done<=1, go to DONE. For a read (mem_we=0), owner's rdata<=mem_rdata. For a write, rdata is unchanged.
  - mem_ready=0 and counter==TIMEOUT-1: abort. mem_en<=0, err<=1 (sticky until reset), owner's rdata<=0, owner's done<=1, go to DONE.
  - Otherwise: counter increments.
  - mem_ready arriving on the timeout cycle: ready wins, err is not set.
- DONE:
  - One cycle. done=1 for the owner only; mem_en=0.
  - Requests are not sampled. Next state is IDLE, where done<=0.
- mem_ready is ignored in IDLE and DONE.
- Requester rules:
  - Hold req and its fields stable until done is seen.
  - In the cycle after done, deassert req or present a new request. A high req in IDLE is always a new access.
  - Dropping req during BUSY does not cancel the access; done still pulses.
- The losing requester keeps req high and is granted at the next IDLE.
- Latency with zero-wait memory:
  - req seen in IDLE at cycle 0 → mem_en in cycle 1 → done in cycle 2 → IDLE in cycle 3.
  - Minimum 3 cycles per access; a back-to-back next access issues mem_en in cycle 4.
- Counter width: clog2(TIMEOUT+1).

Test Plan:
- CPU read, zero-wait: cpu_req=1, we=0, addr=0x10; mem_ready=1 in cycle 1 with mem_rdata=0xCAFEF00D → mem_en/mem_addr=0x10 in cycle 1, cpu_done and cpu_rdata=0xCAFEF00D in cycle 2, cpu_stall 1 in cycles 0-1, err=0.
- Write with wait states: dbg_req, we=1, addr=0x40, wdata=0x12345678; mem_ready after 3 BUSY cycles → mem_we=1 and wdata stable throughout, dbg_done exactly one cycle, dbg_rdata unchanged.
- Tie arbitration: both requests held from reset; each completes one access → grant order CPU, DBG, CPU, DBG; no overlapping done pulses; loser's mem_* are never driven early.
- Timeout: cpu read, mem_ready never asserted, TIMEOUT=15 → mem_en high exactly 15 cycles, then cpu_done=1, cpu_rdata=0, err=1 and stays 1. A following successful access keeps err=1.
- Ready on the boundary: mem_ready first asserted in the 15th BUSY cycle → normal completion, err=0.
- Reset mid-access: assert rst during BUSY → mem_en, done and err go to 0 asynchronously, with no done pulse after reset release. Next tie grants CPU first.
